// File: rtl/uart_seq_tx.sv
// Periodic UART sender: a period timer requests frames, a sequencer supplies an
// arithmetic value series, and a serializer emits start/data/parity/stop bits.
module uart_seq_tx #(
  parameter int F         = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int PERIOD    = 50000000,
  parameter int START     = 0,
  parameter int STEP      = 1,
  parameter int COUNT     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 tx,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] data,
  output logic                 overrun
);
  // state    | meaning
  // S_IDLE   | line high, waiting for a period tick
  // S_START  | start bit (low)
  // S_DATA   | payload bits, LSB first
  // S_PARITY | parity bit, only reached when PARITY != 0
  // S_STOP   | stop bit(s); done pulses in the final cycle
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  localparam int CPB = F / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int PW  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int IW  = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int NW  = $clog2(DATA_BITS);
  localparam logic [DATA_BITS-1:0] START_V = DATA_BITS'(START);
  localparam logic [DATA_BITS-1:0] STEP_V  = DATA_BITS'(STEP);

  state_t               r_state, w_state_nxt;
  logic [CW-1:0]        r_bcnt, w_bcnt_nxt;
  logic [NW-1:0]        r_nbit, w_nbit_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_tx, w_tx_nxt;
  logic [DATA_BITS-1:0] r_data, r_val;
  logic [IW-1:0]        r_idx;
  logic [PW-1:0]        r_pcnt;
  logic                 r_ovr;
  logic                 w_tick, w_busy, w_load, w_bit_end, w_last, w_par;

  assign w_tick    = en && (r_pcnt == PW'(PERIOD - 1));
  assign w_busy    = (r_state != S_IDLE);
  assign w_bit_end = (r_bcnt == '0);
  assign w_last    = (r_idx == IW'(COUNT - 1));
  assign w_par     = (PARITY == 1) ? ~^r_data : ^r_data;

  assign tx      = r_tx;
  assign busy    = w_busy;
  assign done    = (r_state == S_STOP) && w_bit_end && (r_nbit == '0);
  assign data    = r_data;
  assign overrun = r_ovr;

  always_comb begin
    w_state_nxt = r_state;
    w_bcnt_nxt  = w_bit_end ? r_bcnt : r_bcnt - 1'b1;
    w_nbit_nxt  = r_nbit;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_tick) begin
          w_load      = 1'b1;
          w_shift_nxt = r_val;
          w_bcnt_nxt  = CW'(CPB - 1);
          w_tx_nxt    = 1'b0;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_bcnt_nxt  = CW'(CPB - 1);
          w_nbit_nxt  = NW'(DATA_BITS - 1);
          w_tx_nxt    = r_shift[0];
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_bcnt_nxt = CW'(CPB - 1);
          if (r_nbit != '0) begin
            w_nbit_nxt  = r_nbit - 1'b1;
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
          end else if (PARITY != 0) begin
            w_tx_nxt    = w_par;
            w_state_nxt = S_PARITY;
          end else begin
            w_nbit_nxt  = NW'(STOP_BITS - 1);
            w_tx_nxt    = 1'b1;
            w_state_nxt = S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_bcnt_nxt  = CW'(CPB - 1);
          w_nbit_nxt  = NW'(STOP_BITS - 1);
          w_tx_nxt    = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        w_tx_nxt = 1'b1;
        if (w_bit_end) begin
          if (r_nbit == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_nbit_nxt = r_nbit - 1'b1;
            w_bcnt_nxt = CW'(CPB - 1);
          end
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_bcnt  <= '0;
      r_nbit  <= '0;
      r_shift <= START_V;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_nbit  <= w_nbit_nxt;
      r_shift <= w_shift_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  // Requests arriving while a frame is in flight (done cycle included) are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pcnt <= '0;
      r_idx  <= '0;
      r_val  <= START_V;
      r_data <= START_V;
      r_ovr  <= 1'b0;
    end else begin
      if (!en || w_tick) r_pcnt <= '0;
      else               r_pcnt <= r_pcnt + 1'b1;
      if (w_load) begin
        r_data <= r_val;
        if (w_last) begin
          r_idx <= '0;
          r_val <= START_V;
        end else begin
          r_idx <= r_idx + 1'b1;
          r_val <= r_val + STEP_V;
        end
      end
      if (w_tick && w_busy) r_ovr <= 1'b1;
    end
  end
endmodule

// File: doc/uart_seq_tx.md
# uart_seq_tx

Periodic UART sequence transmitter. It generalises the fixed "counter drives 3-bit value into UART once per second" test sender into one parametrised block. The block contains a period timer, an arithmetic value sequencer with configurable start, step and length, and an integrated serializer with configurable data width, parity and stop bits. It also reports busy, frame completion and overrun. It sits at board top level as a self-test or heartbeat source driving a UART TX pin.

## Interface
- `F`, 50000000, clock frequency in Hz.
- `BAUD`, 115200, bit rate; `CLKS_PER_BIT = F / BAUD` (integer division, must be ≥ 2).
- `DATA_BITS`, 8, payload bits per frame, 5..9.
- `PARITY`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits, 1 or 2.
- `PERIOD`, 50000000, clock cycles between send requests, ≥ 1.
- `START`, 0, first sequence value (`DATA_BITS` wide).
- `STEP`, 1, increment per sent frame, modulo 2^DATA_BITS.
- `COUNT`, 8, sequence length before returning to `START`, ≥ 1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  enables the period timer.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while a frame is in flight.
- `done`  out  1  one-cycle pulse in the last cycle of the last stop bit.
- `data`  out  DATA_BITS  value of the current or most recent frame.
- `overrun`  out  1  sticky; set when a request is dropped.

## Operation
- Period timer `pcnt` counts 0..PERIOD-1 while `en`=1, then wraps to 0.
  - `tick` = `en` && `pcnt`==PERIOD-1.
  - `en`=0 clears `pcnt` to 0. A frame already in flight always completes.
- Sequencer holds `idx` (0..COUNT-1) and `val`.
  - On each accepted tick: `val` ← `val`+STEP (mod 2^DATA_BITS) and `idx` increments.
  - When `idx` reaches COUNT-1, the next accept returns `val` to START and `idx` to 0.
- FSM states: IDLE → START → DATA → PARITY (skipped if PARITY=0) → STOP → IDLE.
  - IDLE: `tx`=1. On `tick`, load the shifter with `val`, set `data`←`val`, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: LSB first, DATA_BITS bits, CLKS_PER_BIT cycles each.
  - PARITY: `tx` = XOR of payload (even mode) or its inverse (odd mode).
  - STOP: `tx`=1 for STOP_BITS×CLKS_PER_BIT cycles. `done`=1 in the final cycle; the next state is IDLE.
- `busy` = (state ≠ IDLE).
- A `tick` while `busy`=1, including the `done` cycle, is dropped: `overrun`←1 and `val`/`idx` are unchanged.
- `tx` is registered, so no glitches occur.
- Frame length `L` = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.

## Timing
- Reset (`rst`=0, asynchronous, any state including mid-frame), all immediate:
  - `tx`=1, `busy`=0, `done`=0, `overrun`=0.
  - `data`=START, `val`=START, `idx`=0, `pcnt`=0, state IDLE.
- After reset release with `en`=1, the first `tick` occurs in cycle PERIOD-1, counting the first active edge as cycle 0.
- Latency is 1 cycle from `tick` to `tx` falling.
  - `busy` and `data` update on the same edge as `tx` falls.
- `busy` stays high for exactly `L` cycles. `done` is coincident with the last of them.
- Back-to-back frames occur only if a tick lands in the first IDLE cycle after `done`.
- `overrun` is cleared only by reset.

## Test plan
- F=16, BAUD=4 (CLKS_PER_BIT=4), DATA_BITS=8, PARITY=0, STOP_BITS=1, PERIOD=50, START=0, STEP=1, COUNT=8, `en`=1 → `tx` low over cycles 50..53; bits of 0x00 over 54..85; stop over 86..89; `done` in cycle 89; `overrun` stays 0.
- Same configuration, run 9 periods → `data` sequence 0,1,2,3,4,5,6,7,0 (wrap after COUNT); each frame's sampled payload matches `data`.
- PARITY=2, START=0x05 → parity bit 0. PARITY=1, START=0x05 → parity bit 1. DATA_BITS=7, STOP_BITS=2, PARITY=0 → `busy` length (1+7+0+2)×4=40 cycles.
- PERIOD=20, base configuration (L=40) → frame starts after tick at cycle 19; ticks at 39 and 59 are dropped (59 is the `done` cycle) and `overrun`=1; tick at 79 is accepted with `data`=1, not 3.
- Drive `en`=0 mid-frame → frame completes normally; no further ticks occur. `en`=1 again → next tick arrives PERIOD-1 cycles later.
- Assert `rst`=0 during DATA bit 3 → `tx`=1 and `busy`=0 immediately. After release, the next frame sends START with correct timing.
